// File: rtl/uart_pkg.sv
// Shared encodings and constants for the UART TX/RX engines.
// UART_PARITY_EN adds the PARITY state to the shared encoding.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_START  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_fifo_core_if.sv
// Host-side bus of uart_fifo_core: TX push, RX pop and sticky error flags.
// UART_PARITY_EN adds the rx_parity_err flag.
interface uart_fifo_core_if #(
  parameter int DBIT = 8
);
  logic            wr_en;
  logic [DBIT-1:0] w_data;
  logic            tx_full;
  logic            tx_busy;
  logic            rd_en;
  logic [DBIT-1:0] r_data;
  logic            rx_empty;
  logic            rx_frame_err;
  logic            rx_overrun;
  logic            err_clr;
`ifdef UART_PARITY_EN
  logic            rx_parity_err;

  modport master (
    output wr_en, w_data, rd_en, err_clr,
    input  tx_full, tx_busy, r_data, rx_empty, rx_frame_err, rx_overrun, rx_parity_err
  );
  modport slave (
    input  wr_en, w_data, rd_en, err_clr,
    output tx_full, tx_busy, r_data, rx_empty, rx_frame_err, rx_overrun, rx_parity_err
  );
`else
  modport master (
    output wr_en, w_data, rd_en, err_clr,
    input  tx_full, tx_busy, r_data, rx_empty, rx_frame_err, rx_overrun
  );
  modport slave (
    input  wr_en, w_data, rd_en, err_clr,
    output tx_full, tx_busy, r_data, rx_empty, rx_frame_err, rx_overrun
  );
`endif
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; output holds the last popped
// word while empty.
module uart_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);
  localparam int DEPTH = 2**AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_last;
  logic          w_full, w_empty, w_do_wr, w_do_rd;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // A write while full is allowed only when a read frees the slot this cycle.
  assign w_do_wr = i_wr && (!w_full || i_rd);
  assign w_do_rd = i_rd && !w_empty;

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr];
      end
      if (w_do_wr && !w_do_rd)      r_count <= r_count + 1'b1;
      else if (!w_do_wr && w_do_rd) r_count <= r_count - 1'b1;
    end
  end

  assign o_rdata = w_empty ? r_last : r_mem[r_rptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
endmodule

// File: rtl/uart_fifo_core.sv
// UART core: programmable baud tick, 16x-oversampling RX, TX, per-direction
// FIFOs and sticky error flags. Define UART_PARITY_EN for even parity.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 11,
  parameter int FIFO_AW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              rx,
  output logic              tx,
  uart_fifo_core_if.slave   bus
);
  localparam int SW = 6;
  localparam int NW = $clog2(DBIT);

  logic [DVSR_W-1:0] r_tick_cnt, w_term;
  logic              w_tick;

  assign w_term = (dvsr == '0) ? '0 : dvsr - DVSR_W'(1);
  assign w_tick = (r_tick_cnt == w_term);

  // >= rather than == so a shrinking divisor wraps immediately.
  always_ff @(posedge clk) begin
    if (reset)                    r_tick_cnt <= '0;
    else if (r_tick_cnt >= w_term) r_tick_cnt <= '0;
    else                          r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  logic            r_rx_meta, r_rx_sync, r_rx_push;
  uart_state_e     r_rx_state;
  logic [SW-1:0]   r_rx_s;
  logic [NW-1:0]   r_rx_n;
  logic [DBIT-1:0] r_rx_b;
  logic            r_frame_err, r_overrun;
  logic            w_rx_full;
`ifdef UART_PARITY_EN
  logic            r_parity_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_push   <= 1'b0;
      r_rx_state  <= ST_IDLE;
      r_rx_s      <= '0;
      r_rx_n      <= '0;
      r_rx_b      <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_push <= 1'b0;
      case (r_rx_state)
        ST_IDLE:
          if (!r_rx_sync) begin
            r_rx_state <= ST_START;
            r_rx_s     <= '0;
          end
        ST_START:
          if (w_tick) begin
            if (r_rx_s == SW'(MID_START)) begin
              r_rx_s <= '0;
              r_rx_n <= '0;
              r_rx_state <= r_rx_sync ? ST_IDLE : ST_DATA;
            end else r_rx_s <= r_rx_s + 1'b1;
          end
        ST_DATA:
          if (w_tick) begin
            if (r_rx_s == SW'(OVERSAMPLE-1)) begin
              r_rx_s <= '0;
              r_rx_b <= {r_rx_sync, r_rx_b[DBIT-1:1]};
              if (r_rx_n == NW'(DBIT-1)) begin
`ifdef UART_PARITY_EN
                r_rx_state <= ST_PARITY;
`else
                r_rx_state <= ST_STOP;
`endif
              end else r_rx_n <= r_rx_n + 1'b1;
            end else r_rx_s <= r_rx_s + 1'b1;
          end
`ifdef UART_PARITY_EN
        ST_PARITY:
          if (w_tick) begin
            if (r_rx_s == SW'(OVERSAMPLE-1)) begin
              r_rx_s <= '0;
              if (r_rx_sync != ^r_rx_b) r_parity_err <= 1'b1;
              r_rx_state <= ST_STOP;
            end else r_rx_s <= r_rx_s + 1'b1;
          end
`endif
        ST_STOP:
          if (w_tick) begin
            if (r_rx_s == SW'(SB_TICK-1)) begin
              r_rx_state <= ST_IDLE;
              if (!r_rx_sync)     r_frame_err <= 1'b1;
              else if (w_rx_full) r_overrun   <= 1'b1;
              else                r_rx_push   <= 1'b1;
            end else r_rx_s <= r_rx_s + 1'b1;
          end
        default: r_rx_state <= ST_IDLE;
      endcase
      // Clear wins over a same-cycle set because it is the later assignment.
      if (bus.err_clr) begin
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
        r_parity_err <= 1'b0;
`endif
      end
    end
  end

  uart_state_e     r_tx_state;
  logic [SW-1:0]   r_tx_s;
  logic [NW-1:0]   r_tx_n;
  logic [DBIT-1:0] r_tx_b;
  logic            r_tx;
  logic [DBIT-1:0] w_tx_head;
  logic            w_tx_full, w_tx_empty, w_tx_pop;
`ifdef UART_PARITY_EN
  logic            r_tx_par;
`endif

  // Popping on the last stop tick lets back-to-back frames run without a gap.
  assign w_tx_pop = !w_tx_empty &&
                    ((r_tx_state == ST_IDLE) ||
                     ((r_tx_state == ST_STOP) && w_tick && (r_tx_s == SW'(SB_TICK-1))));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= ST_IDLE;
      r_tx_s     <= '0;
      r_tx_n     <= '0;
      r_tx_b     <= '0;
      r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else if (w_tx_pop) begin
      r_tx_state <= ST_START;
      r_tx_s     <= '0;
      r_tx_b     <= w_tx_head;
      r_tx       <= 1'b0;
`ifdef UART_PARITY_EN
      r_tx_par   <= ^w_tx_head;
`endif
    end else begin
      case (r_tx_state)
        ST_IDLE: r_tx <= 1'b1;
        ST_START:
          if (w_tick) begin
            if (r_tx_s == SW'(OVERSAMPLE-1)) begin
              r_tx_s     <= '0;
              r_tx_n     <= '0;
              r_tx_state <= ST_DATA;
              r_tx       <= r_tx_b[0];
            end else r_tx_s <= r_tx_s + 1'b1;
          end
        ST_DATA:
          if (w_tick) begin
            if (r_tx_s == SW'(OVERSAMPLE-1)) begin
              r_tx_s <= '0;
              r_tx_b <= r_tx_b >> 1;
              if (r_tx_n == NW'(DBIT-1)) begin
`ifdef UART_PARITY_EN
                r_tx_state <= ST_PARITY;
                r_tx       <= r_tx_par;
`else
                r_tx_state <= ST_STOP;
                r_tx       <= 1'b1;
`endif
              end else begin
                r_tx_n <= r_tx_n + 1'b1;
                r_tx   <= r_tx_b[1];
              end
            end else r_tx_s <= r_tx_s + 1'b1;
          end
`ifdef UART_PARITY_EN
        ST_PARITY:
          if (w_tick) begin
            if (r_tx_s == SW'(OVERSAMPLE-1)) begin
              r_tx_s     <= '0;
              r_tx_state <= ST_STOP;
              r_tx       <= 1'b1;
            end else r_tx_s <= r_tx_s + 1'b1;
          end
`endif
        ST_STOP:
          if (w_tick) begin
            if (r_tx_s == SW'(SB_TICK-1)) r_tx_state <= ST_IDLE;
            else                          r_tx_s     <= r_tx_s + 1'b1;
          end
        default: r_tx_state <= ST_IDLE;
      endcase
    end
  end

  logic [DBIT-1:0] w_rx_data;
  logic            w_rx_empty;

  uart_sync_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .reset(reset),
    .i_wr(bus.wr_en), .i_wdata(bus.w_data), .i_rd(w_tx_pop),
    .o_rdata(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  uart_sync_fifo #(.DW(DBIT), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .reset(reset),
    .i_wr(r_rx_push), .i_wdata(r_rx_b), .i_rd(bus.rd_en),
    .o_rdata(w_rx_data), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  assign tx               = r_tx;
  assign bus.tx_full      = w_tx_full;
  assign bus.tx_busy      = (r_tx_state != ST_IDLE) || !w_tx_empty;
  assign bus.r_data       = w_rx_data;
  assign bus.rx_empty     = w_rx_empty;
  assign bus.rx_frame_err = r_frame_err;
  assign bus.rx_overrun   = r_overrun;
`ifdef UART_PARITY_EN
  assign bus.rx_parity_err = r_parity_err;
`endif
endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core at dvsr=4 (64 clk per bit), 8N1, depth 4.
module tb_uart_fifo_core;
  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr;
  logic        rx, tx;
  logic        loop_en, rx_drv;
  logic        mon_en;
  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;

  uart_fifo_core_if #(.DBIT(8)) bus();

  uart_fifo_core #(.DBIT(8), .SB_TICK(16), .DVSR_W(11), .FIFO_AW(2)) dut (
    .clk(clk), .reset(reset), .dvsr(dvsr), .rx(rx), .tx(tx), .bus(bus)
  );

  assign rx = loop_en ? tx : rx_drv;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the RX FIFO whenever data is presented and compares to the queue.
  initial begin
    bus.rd_en = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rd_en) bus.rd_en = 1'b0;
      else if (mon_en && !reset && !bus.rx_empty) begin
        if (exp_q.size() == 0) chk("rx_unexpected_byte", int'(bus.r_data), -1);
        else                   chk("rx_data", int'(bus.r_data), int'(exp_q.pop_front()));
        bus.rd_en = 1'b1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    bus.w_data = b;
    bus.wr_en  = 1'b1;
    @(negedge clk);
    bus.wr_en  = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(b);
    push(b);
  endtask

  task automatic check_tx_frame(input logic [7:0] b, output int lat);
    logic [9:0] pat;
    bit found;
    pat = {1'b1, b, 1'b0};
    found = 1'b0;
    lat = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!tx) begin found = 1'b1; lat = i; end
    end
    chk("tx_start_seen", int'(found), 1);
    if (found) begin
      repeat (32) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("tx_bit%0d_of_%02h", k, b), int'(tx), int'(pat[k]));
        if (k < 9) repeat (64) @(negedge clk);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_stop);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (64) @(negedge clk);
    end
    if (bad_stop) begin
      rx_drv = 1'b0;
      repeat (40) @(negedge clk);
      rx_drv = 1'b1;
      repeat (24) @(negedge clk);
    end else begin
      rx_drv = 1'b1;
      repeat (64) @(negedge clk);
    end
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !bus.tx_busy && bus.rx_empty;
    end
    repeat (200) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("rx_empty_after_drain", int'(bus.rx_empty), 1);
  endtask

  task automatic clear_errors();
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit dropped;
    reset = 1'b1; dvsr = 11'd4; loop_en = 1'b1; rx_drv = 1'b1; mon_en = 1'b1;
    bus.wr_en = 1'b0; bus.w_data = '0; bus.err_clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_tx", int'(tx), 1);
    chk("reset_tx_full", int'(bus.tx_full), 0);
    chk("reset_tx_busy", int'(bus.tx_busy), 0);
    chk("reset_rx_empty", int'(bus.rx_empty), 1);
    chk("reset_r_data", int'(bus.r_data), 0);
    chk("reset_frame_err", int'(bus.rx_frame_err), 0);
    chk("reset_overrun", int'(bus.rx_overrun), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame 0xA5 looped back
    push_exp(8'hA5);
    check_tx_frame(8'hA5, lat);
    chk("tx_pop_latency", lat, 0);
    chk("tx_busy_in_stop", int'(bus.tx_busy), 1);
    dropped = 1'b0;
    for (int i = 0; i < 40 && !dropped; i++) begin
      @(negedge clk);
      dropped = !bus.tx_busy;
    end
    chk("tx_busy_drop", int'(bus.tx_busy), 0);
    drain(2000);

    // Back-to-back frames through loopback
    push_exp(8'h00);
    push_exp(8'hFF);
    push_exp(8'h3C);
    drain(4000);
    chk("r_data_holds_last", int'(bus.r_data), 8'h3C);

    // Short low glitch on rx
    loop_en = 1'b0;
    repeat (10) @(negedge clk);
    rx_drv = 1'b0;
    repeat (16) @(negedge clk);
    rx_drv = 1'b1;
    repeat (800) @(negedge clk);
    chk("glitch_rx_empty", int'(bus.rx_empty), 1);
    chk("glitch_frame_err", int'(bus.rx_frame_err), 0);
    chk("glitch_overrun", int'(bus.rx_overrun), 0);

    // Low stop bit
    send_frame(8'h55, 1'b1);
    repeat (100) @(negedge clk);
    chk("frame_err_set", int'(bus.rx_frame_err), 1);
    chk("frame_err_no_push", int'(bus.rx_empty), 1);
    chk("frame_err_no_overrun", int'(bus.rx_overrun), 0);
    clear_errors();
    chk("frame_err_cleared", int'(bus.rx_frame_err), 0);

    // Overrun: five frames into a depth-4 FIFO with no reads
    mon_en = 1'b0;
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    send_frame(8'h33, 1'b0);
    send_frame(8'h44, 1'b0);
    chk("overrun_before_fifth", int'(bus.rx_overrun), 0);
    chk("rx_nonempty_after_four", int'(bus.rx_empty), 0);
    send_frame(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    chk("overrun_set", int'(bus.rx_overrun), 1);
    chk("overrun_no_frame_err", int'(bus.rx_frame_err), 0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    mon_en = 1'b1;
    drain(200);
    clear_errors();
    chk("overrun_cleared", int'(bus.rx_overrun), 0);

    // TX FIFO full: first byte goes straight to the engine, four more fill it
    loop_en = 1'b1;
    push_exp(8'h01);
    repeat (2) @(negedge clk);
    push_exp(8'h02);
    push_exp(8'h03);
    push_exp(8'h04);
    chk("tx_full_at_three", int'(bus.tx_full), 0);
    push_exp(8'h05);
    chk("tx_full_at_four", int'(bus.tx_full), 1);
    push(8'h06);
    chk("tx_full_after_ignored_write", int'(bus.tx_full), 1);
    drain(6000);

    // Reset in the middle of the data bits
    push(8'h0F);
    for (int i = 0; i < 200 && tx; i++) @(negedge clk);
    repeat (200) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_tx", int'(tx), 1);
    chk("midreset_tx_busy", int'(bus.tx_busy), 0);
    chk("midreset_rx_empty", int'(bus.rx_empty), 1);
    chk("midreset_tx_full", int'(bus.tx_full), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    push_exp(8'hC3);
    check_tx_frame(8'hC3, lat);
    chk("post_reset_pop_latency", lat, 0);
    drain(2000);
    chk("post_reset_frame_err", int'(bus.rx_frame_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
